// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, latency.
package mdu_pkg;

    localparam int MDU_WIDTH   = 32;
    localparam int MDU_LATENCY = MDU_WIDTH + 2;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_addsub.sv
// N-bit add/subtract built from per-bit generate/propagate/sum cells.
module mdu_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N-1:0] y_s;
    logic [N-1:0] g_s;
    logic [N-1:0] p_s;
    logic [N:0]   c_s;

    // Per-bit g/p cells and carry chain; subtraction is x + ~y + 1
    always_comb begin
        y_s    = y ^ {N{sub}};
        g_s    = x & y_s;
        p_s    = x ^ y_s;
        c_s    = '0;
        c_s[0] = sub;
        for (int i = 0; i < N; i++) begin
            c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
        end
        s    = p_s ^ c_s[N-1:0];
        cout = c_s[N];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO: shift-add multiply,
// restoring divide, sign handled by magnitude conversion before and after.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] a_r, b_r, acc_r, wlo_r, opnd_r, hi_r, lo_r;
    logic [CW-1:0]    cnt_r;
    logic             is_div_r, is_signed_r, neg_q_r, neg_r_r, dz_r;
    logic             busy_r, done_r, dbz_r;

    logic             idle_free_s, accept_s, mt_s;
    logic             a_neg_s, b_neg_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH:0]   add_x_s, add_y_s, add_sum_s;
    logic             add_sub_s, add_cout_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] fix_hi_s, fix_lo_s;

    // Request decode: only an idle, non-busy unit takes a new op
    always_comb begin
        idle_free_s = start && !busy_r && (state_r == IDLE);
        accept_s    = idle_free_s && ((op == OP_MULT) || (op == OP_MULTU) ||
                                      (op == OP_DIV)  || (op == OP_DIVU));
        mt_s        = idle_free_s && ((op == OP_MTHI) || (op == OP_MTLO));
    end

    // Operand magnitudes for signed ops
    always_comb begin
        a_neg_s = is_signed_r & a_r[WIDTH-1];
        b_neg_s = is_signed_r & b_r[WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = ~a_r + WIDTH'(1);
        end else begin
            a_mag_s = a_r;
        end
        if (b_neg_s) begin
            b_mag_s = ~b_r + WIDTH'(1);
        end else begin
            b_mag_s = b_r;
        end
    end

    // Shared adder: conditional add for multiply, trial subtract for divide
    always_comb begin
        if (is_div_r) begin
            add_x_s   = {acc_r, wlo_r[WIDTH-1]};
            add_y_s   = {1'b0, opnd_r};
            add_sub_s = 1'b1;
        end else begin
            add_x_s   = {1'b0, acc_r};
            add_sub_s = 1'b0;
            if (wlo_r[0]) begin
                add_y_s = {1'b0, opnd_r};
            end else begin
                add_y_s = '0;
            end
        end
    end

    mdu_addsub #(.N(WIDTH + 1)) u_addsub (
        .x    (add_x_s),
        .y    (add_y_s),
        .sub  (add_sub_s),
        .s    (add_sum_s),
        .cout (add_cout_s)
    );

    // Final sign correction and divide-by-zero result
    always_comb begin
        prod_s = {acc_r, wlo_r};
        if (neg_q_r) begin
            prod_s = ~prod_s + (2*WIDTH)'(1);
        end else begin
            prod_s = {acc_r, wlo_r};
        end
        if (dz_r) begin
            fix_hi_s = a_r;
            fix_lo_s = '1;
        end else if (is_div_r) begin
            fix_hi_s = neg_r_r ? (~acc_r + WIDTH'(1)) : acc_r;
            fix_lo_s = neg_q_r ? (~wlo_r + WIDTH'(1)) : wlo_r;
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // FSM next state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = PREP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PREP: begin
                if (is_div_r && (b_r == '0)) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            RUN: begin
                if (cnt_r == '0) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath, HI/LO and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            wlo_r       <= '0;
            opnd_r      <= '0;
            hi_r        <= '0;
            lo_r        <= '0;
            cnt_r       <= '0;
            is_div_r    <= 1'b0;
            is_signed_r <= 1'b0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            dz_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            done_r <= (state_r == FIX);
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (done_r) begin
                busy_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r         <= a;
                        b_r         <= b;
                        is_div_r    <= (op == OP_DIV) || (op == OP_DIVU);
                        is_signed_r <= (op == OP_MULT) || (op == OP_DIV);
                        dz_r        <= 1'b0;
                        dbz_r       <= 1'b0;
                    end else if (mt_s) begin
                        if (op == OP_MTHI) begin
                            hi_r <= a;
                        end else begin
                            lo_r <= a;
                        end
                    end
                end
                PREP: begin
                    acc_r   <= '0;
                    cnt_r   <= CW'(WIDTH - 1);
                    neg_q_r <= a_neg_s ^ b_neg_s;
                    neg_r_r <= a_neg_s;
                    dz_r    <= is_div_r && (b_r == '0);
                    // Divide iterates the dividend out of wlo; multiply shifts the multiplier
                    if (is_div_r) begin
                        wlo_r  <= a_mag_s;
                        opnd_r <= b_mag_s;
                    end else begin
                        wlo_r  <= b_mag_s;
                        opnd_r <= a_mag_s;
                    end
                end
                RUN: begin
                    cnt_r <= cnt_r - CW'(1);
                    if (is_div_r) begin
                        acc_r <= add_cout_s ? add_sum_s[WIDTH-1:0] : add_x_s[WIDTH-1:0];
                        wlo_r <= {wlo_r[WIDTH-2:0], add_cout_s};
                    end else begin
                        acc_r <= add_sum_s[WIDTH:1];
                        wlo_r <= {add_sum_s[0], wlo_r[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi_r  <= fix_hi_s;
                    lo_r  <= fix_lo_s;
                    dbz_r <= dz_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expectations come from a 64-bit
// behavioural model and are popped when done pulses.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t         sb_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] sh_hi = '0;
    logic [W-1:0] sh_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        longint      sx, sy;
        logic [63:0] p;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        e.dz  = 1'b0;
        e.lat = MDU_LATENCY;
        e.hi  = '0;
        e.lo  = '0;
        if ((o == OP_DIV || o == OP_DIVU) && y == '0) begin
            // no RUN phase: PREP goes straight to FIX
            e.hi  = x;
            e.lo  = '1;
            e.dz  = 1'b1;
            e.lat = 2;
        end else begin
            case (o)
                OP_MULTU: p = 64'(x) * 64'(y);
                OP_MULT:  p = 64'(sx * sy);
                OP_DIVU:  p = {64'(x % y)} << 32 | 64'(x / y);
                OP_DIV:   p = {64'(sx % sy)} << 32 | {32'h0, 32'(sx / sy)};
                default:  p = 64'h0;
            endcase
            e.hi = p[63:32];
            e.lo = p[31:0];
        end
        return e;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b1; op = o; a = x; b = y;
        if (o <= 3'd3) sb_q.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat0);
        exp_t e;
        int   lat = lat0;
        bit   seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                check_eq("hold_hi", hi, sh_hi);
                check_eq("hold_lo", lo, sh_lo);
            end
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check_eq("done_timeout", 64'd0, 64'd1);
        end else if (sb_q.size() == 0) begin
            check_eq("unexpected_done", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq("hi", hi, e.hi);
            check_eq("lo", lo, e.lo);
            check_eq("dbz", div_by_zero, e.dz);
            check_eq("latency", lat, e.lat);
            check_eq("busy_at_done", busy, 1'b1);
            sh_hi = e.hi;
            sh_lo = e.lo;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        issue(o, x, y);
        check_eq("busy_after_accept", busy, 1'b1);
        wait_done(0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_hi", hi, 32'h0);
        check_eq("rst_lo", lo, 32'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_dbz", div_by_zero, 1'b0);
        rst_n = 1'b1;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
        run_op(OP_DIVU,  32'h0000_0007, 32'h0000_0002);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_DIVU,  32'h0000_0005, 32'h0000_0000);
        run_op(OP_DIV,   32'hFFFF_FF00, 32'h0000_0000);
        run_op(OP_DIV,   32'h0000_0064, 32'hFFFF_FFF9);
        for (int i = 0; i < 8; i++) begin
            run_op(3'(i % 4), $urandom, (i > 3) ? 32'($urandom_range(1, 1000)) : $urandom);
        end

        // MTHI/MTLO while idle: immediate, no busy
        issue(OP_MTHI, 32'h0000_1234, 32'h0);
        check_eq("mthi_hi", hi, 32'h0000_1234);
        check_eq("mthi_busy", busy, 1'b0);
        issue(OP_MTLO, 32'hCAFE_0001, 32'h0);
        check_eq("mtlo_lo", lo, 32'hCAFE_0001);
        check_eq("mtlo_hi", hi, 32'h0000_1234);
        sh_hi = 32'h0000_1234;
        sh_lo = 32'hCAFE_0001;
        issue(3'd6, 32'h5555_5555, 32'h1);
        check_eq("op6_busy", busy, 1'b0);
        check_eq("op6_hi", hi, sh_hi);

        // starts while busy are dropped; HI/LO hold until done
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        repeat (3) @(negedge clk);
        start = 1'b1; op = OP_MTLO; a = 32'hDEAD_BEEF;
        @(negedge clk);
        op = OP_MULT; a = 32'h3; b = 32'h3;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_hold_hi", hi, sh_hi);
        check_eq("busy_hold_lo", lo, sh_lo);
        wait_done(5);
        // start in the done cycle is ignored
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'h0000_ABCD;
        @(negedge clk);
        start = 1'b0;
        check_eq("done_cycle_start_hi", hi, sh_hi);
        repeat (5) @(posedge clk);
        #1;
        check_eq("no_restart_busy", busy, 1'b0);

        // async reset during RUN discards the operation
        issue(OP_MULTU, 32'h0123_4567, 32'h0000_89AB);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_hi", hi, 32'h0);
        check_eq("arst_lo", lo, 32'h0);
        check_eq("arst_busy", busy, 1'b0);
        sb_q.delete();
        sh_hi = '0;
        sh_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_MULTU, 32'd6, 32'd7);
        check_eq("post_rst_lo", lo, 32'd42);
        check_eq("post_rst_hi", hi, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
